// File: rtl/framebuffer_port_scheduler.sv
// framebuffer_port_scheduler
//
// Purpose:
//   Shares the single read/write port of a double-buffered framebuffer RAM
//   between pixel scan-out reads and GPU draw writes. Scan-out always wins the
//   port and has a fixed return latency. GPU writes use a valid/ready handshake
//   and always land in the back buffer. A buffer-swap request is latched and
//   only applied at the next frame boundary. While a swap is pending, writes are
//   blocked so the completed back buffer cannot be disturbed before it is shown.
//
// Ports:
//   clk_i, reset_i        pixel clock, synchronous active-high reset
//   scan_valid_i/addr_i   one pixel read request per cycle from the video controller
//   scan_data_o/valid_o   returned pixel, MEM_LATENCY+2 cycles after the request
//   wr_valid_i/addr_i/
//   wr_data_i/ready_o     GPU write handshake (ready is combinational)
//   swap_req_i            pulse: back buffer complete, swap at the next frame end
//   frame_end_i           pulse at the last pixel of a frame
//   swap_pending_o        a swap is latched and waiting for frame_end_i
//   front_buf_o           index of the buffer currently being scanned
//   frame_count_o         number of applied swaps (wraps)
//   mem_en_o/we_o/addr_o/
//   wdata_o               registered RAM port; addr is {buffer bit, pixel address}
//   mem_rdata_i           RAM read data, valid MEM_LATENCY cycles after mem_en_o

module framebuffer_port_scheduler #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              scan_valid_i,
  input  logic [ADDR_W-1:0] scan_addr_i,
  output logic [DATA_W-1:0] scan_data_o,
  output logic              scan_data_valid_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              swap_req_i,
  input  logic              frame_end_i,
  output logic              swap_pending_o,
  output logic              front_buf_o,
  output logic [CNT_W-1:0]  frame_count_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t            state;
  logic                   front_buf;
  logic [CNT_W-1:0]       frame_count;
  logic [MEM_LATENCY-1:0] rd_tag;
  logic                   rd_issue;

  assign swap_pending_o = (state == PENDING);
  assign front_buf_o    = front_buf;
  assign frame_count_o  = frame_count;

  // A write can only take the port when no scan wants it this cycle and the
  // back buffer is not frozen waiting for a swap.
  assign wr_ready_o = !scan_valid_i && !swap_pending_o && !reset_i;

  // Swap FSM. In IDLE a frame_end_i is ignored even when it coincides with
  // swap_req_i, so the swap always waits for a full frame boundary after the
  // request has been latched.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      front_buf   <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (swap_req_i) begin
            state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_end_i) begin
            state       <= IDLE;
            front_buf   <= !front_buf;
            frame_count <= frame_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port arbitration. The buffer bit is taken from front_buf as it stands in
  // the request cycle, so a scan coinciding with the swapping frame_end_i still
  // reads the old front buffer. Idle cycles keep addr/wdata stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (scan_valid_i) begin
      mem_en_o   <= 1'b1;
      mem_we_o   <= 1'b0;
      mem_addr_o <= {front_buf, scan_addr_i};
    end else if (wr_valid_i && wr_ready_o) begin
      mem_en_o    <= 1'b1;
      mem_we_o    <= 1'b1;
      mem_addr_o  <= {!front_buf, wr_addr_i};
      mem_wdata_o <= wr_data_i;
    end else begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
    end
  end

  // A tag enters the pipeline in the cycle the read is on the RAM port and
  // reaches the last stage in the cycle the RAM presents the data.
  assign rd_issue = mem_en_o && !mem_we_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_tag <= '0;
    end else begin
      rd_tag <= (rd_tag << 1) | MEM_LATENCY'(rd_issue);
    end
  end

  // Capture the read data when its tag emerges; the data register holds its
  // last pixel otherwise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scan_data_o       <= '0;
      scan_data_valid_o <= 1'b0;
    end else begin
      scan_data_valid_o <= rd_tag[MEM_LATENCY-1];
      if (rd_tag[MEM_LATENCY-1]) begin
        scan_data_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: doc/framebuffer_port_scheduler.md
# framebuffer_port_scheduler

Shares the single read/write port of the double-buffered framebuffer memory between pixel scan-out and GPU draw writes. It sits between the video controller and the framebuffer RAM. Scan-out reads always have priority and fixed latency. GPU writes use a valid/ready handshake and always target the back buffer. A buffer-swap request is latched and applied only at the frame boundary, and GPU writes are fenced off while a swap is pending.

## Interface
- ADDR_W, 19: pixel address width within one buffer (≥ 800×600 pixels)
- DATA_W, 8: pixel (palette index) width
- MEM_LATENCY, 1: framebuffer read latency in cycles, from registered mem_en_o to mem_rdata_i valid; range ≥1
- CNT_W, 16: width of frame_count_o
- clk_i  in  1  pixel clock
- reset_i  in  1  synchronous, active-high reset
- scan_valid_i  in  1  video controller requests one pixel this cycle
- scan_addr_i  in  ADDR_W  pixel address in the front buffer
- scan_data_o  out  DATA_W  returned pixel
- scan_data_valid_o  out  1  scan_data_o valid
- wr_valid_i  in  1  GPU write request
- wr_addr_i  in  ADDR_W  pixel address in the back buffer
- wr_data_i  in  DATA_W  pixel value
- wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o
- swap_req_i  in  1  single-cycle pulse: back buffer is complete, swap at the next frame end
- frame_end_i  in  1  single-cycle pulse at the last pixel of the frame, driven by the timing generator
- swap_pending_o  out  1  swap latched, not yet applied
- front_buf_o  out  1  index of the buffer being scanned
- frame_count_o  out  CNT_W  number of completed swaps, wraps modulo 2^CNT_W
- mem_en_o  out  1  memory access strobe, registered
- mem_we_o  out  1  write enable, registered
- mem_addr_o  out  ADDR_W+1  {buffer bit, pixel address}, registered
- mem_wdata_o  out  DATA_W  write data, registered
- mem_rdata_i  in  DATA_W  read data

## Operation
- Swap FSM has two states.
  - IDLE: swap_req_i moves to PENDING on the next edge.
  - PENDING: frame_end_i toggles front_buf, increments frame_count_o and returns to IDLE.
  - swap_req_i in PENDING is ignored.
  - swap_req_i and frame_end_i in the same cycle while IDLE: the request is latched and the swap waits for the following frame_end_i.
- swap_pending_o = (state == PENDING).
- wr_ready_o = !scan_valid_i && !swap_pending_o && !reset_i. This is combinational.
- Arbitration per cycle, with the result registered onto the mem_* outputs at the next edge:
  - scan_valid_i: mem_en=1, mem_we=0, mem_addr={front_buf, scan_addr_i}. Scan requests are never stalled.
  - else wr_valid_i && wr_ready_o: mem_en=1, mem_we=1, mem_addr={!front_buf, wr_addr_i}, mem_wdata=wr_data_i.
  - else mem_en=0, mem_we=0; mem_addr and mem_wdata hold their previous values.
- Buffer bit timing:
  - The buffer bit uses front_buf as it is in the request cycle.
  - A scan request in the same cycle as the applying frame_end_i reads the old front buffer.
- Read return:
  - A read-tag shift register of depth MEM_LATENCY tracks issued reads.
  - When the tag emerges, mem_rdata_i is registered into scan_data_o and scan_data_valid_o is set for one cycle.
  - Writes produce no tag.
- Reset values: all mem_* = 0; scan_data_o = 0; scan_data_valid_o = 0; tag pipeline cleared; state = IDLE; front_buf_o = 0; frame_count_o = 0.
- Reset mid-operation:
  - Reads in flight are discarded, with no valid output.
  - A pending swap is dropped.

## Timing
- Scan latency is MEM_LATENCY+2 cycles from scan_valid_i to scan_data_valid_o:
  - request at cycle t
  - mem_en_o at t+1
  - mem_rdata_i at t+1+MEM_LATENCY
  - scan_data_o at t+2+MEM_LATENCY
- Back-to-back scan requests give back-to-back valid outputs, in order, with no bubbles.
- A write accepted at cycle t appears on the mem_* outputs at t+1.
- front_buf_o and frame_count_o change on the edge after frame_end_i when in PENDING.
- swap_pending_o rises on the edge after swap_req_i.

## Test plan
- MEM_LATENCY=1, reset, then scan_valid_i with scan_addr_i=5 for 3 cycles, memory model returning data=addr+1 -> mem_addr_o=0x00005 (buffer bit 0) from cycle 1; scan_data_valid_o high cycles 3–5 with data 6.
- wr_valid_i held high with address 10, data 0xAA, while scan_valid_i pulses every other cycle -> wr_ready_o low exactly in scan cycles; writes go out with mem_we_o=1, mem_addr_o={1,10}; no write is lost or duplicated.
- Pulse swap_req_i, then frame_end_i 100 cycles later:
  - swap_pending_o is 1 for that interval and wr_ready_o is 0 throughout.
  - Afterwards front_buf_o=1, frame_count_o=1, and writes target buffer 0.
- swap_req_i and frame_end_i in the same cycle -> no swap; pending is set; the swap happens at the next frame_end_i.
- A second swap_req_i while pending is ignored -> frame_count_o increments once.
- Assert reset_i with 2 reads in flight and a swap pending (MEM_LATENCY=2) -> no scan_data_valid_o pulses afterwards; front_buf_o=0, frame_count_o=0, swap_pending_o=0, mem_en_o=0.
